// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: run handshake, branch redirect, instruction memory port
// and the fetched-instruction outputs toward the decoder.
// The master side is the environment around the fetch unit. That is the
// controller plus the instruction memory.
// The slave side is the fetch unit itself.
interface fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [PC_W-1:0]    start_pc;
    logic [PC_W-1:0]    prog_end;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    instr_pc;
    logic               busy;
    logic               done;

    modport master (
        output start, start_pc, prog_end, stall, branch_taken, branch_target,
               imem_data,
        input  imem_addr, instr, instr_valid, instr_pc, busy, done
    );

    modport slave (
        input  start, start_pc, prog_end, stall, branch_taken, branch_target,
               imem_data,
        output imem_addr, instr, instr_valid, instr_pc, busy, done
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage.
// It drives a synchronous-read instruction memory and tags each returned word
// with its PC and a valid flag.
// A taken branch squashes the in-flight wrong-path fetch, which costs one bubble.
// A start/done handshake brackets each program run.
module fetch_unit #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic [PC_W-1:0]    end_q;
    logic               instr_valid_q;
    logic               busy_q;
    logic               done_q;

    // Captured copy of the displayed instruction while stalled.
    logic               hold_q;
    logic [INSTR_W-1:0] instr_hold_q;

    logic [PC_W-1:0]    pc_inc;
    logic               redirect;
    logic               finish;
    logic [INSTR_W-1:0] instr_now;

    // Next sequential address. It wraps modulo 2^PC_W.
    assign pc_inc = pc_q + PC_ONE;

    // A branch only counts against an instruction that will really execute.
    // A stall defers the branch, so it is looked at again once the stall clears.
    assign redirect = instr_valid_q & bus.branch_taken & ~bus.stall;

    // The run ends when the last instruction executes without redirecting.
    assign finish = instr_valid_q & (instr_pc_q == end_q) &
                    ~bus.branch_taken & ~bus.stall;

    // Run-control FSM. It also holds the PC and the output-side registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_pc_q    <= '0;
            end_q         <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        pc_q    <= bus.start_pc;
                        end_q   <= bus.prog_end;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end

                // start_pc is on the memory address this cycle.
                // Its data lands in the first RUN cycle.
                FETCH: begin
                    if (!bus.stall) begin
                        pc_q          <= pc_inc;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= RUN;
                    end
                end

                RUN: begin
                    if (bus.stall) begin
                        // Hold everything. The memory re-reads pc_q.
                        state_q <= RUN;
                    end else if (redirect) begin
                        // The word fetched this cycle is wrong-path. Mark the
                        // next cycle invalid and fetch the target instead.
                        pc_q          <= bus.branch_target;
                        instr_valid_q <= 1'b0;
                    end else if (finish) begin
                        instr_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        // Straight-line advance. This also covers the first
                        // cycle after a bubble, when pc_q holds the target.
                        instr_valid_q <= 1'b1;
                        instr_pc_q    <= pc_q;
                        pc_q          <= pc_inc;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Freeze the presented instruction across a stall.
    // With the address held, the memory's next output is mem[pc_q]. That is
    // not the word tagged by instr_pc, so the stalled word is replayed from
    // a capture register until the stall clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= 1'b0;
            instr_hold_q <= '0;
        end else begin
            hold_q       <= bus.stall && (state_q == RUN);
            instr_hold_q <= instr_now;
        end
    end

    assign instr_now       = hold_q ? instr_hold_q : bus.imem_data;

    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_now;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Expected (pc, instr) pairs go into a scoreboard queue as each program is
// launched. A negedge monitor pops one pair per newly presented valid
// instruction and compares it against the DUT output.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] ins;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic stall_at_edge = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    exp_t exp_q[$];

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    // Stall as seen by the edge that produced the current outputs.
    always @(posedge clk) stall_at_edge <= bus.stall;

    // Scoreboard monitor. It consumes only instructions that are newly presented.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.instr_valid && !stall_at_edge) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got pc=%0d instr=%h, expected no instruction",
                         bus.instr_pc, bus.instr);
            end else begin
                e = exp_q.pop_front();
                if (bus.instr_pc !== e.pc || bus.instr !== e.ins) begin
                    n_err++;
                    $display("FAIL sb_instr: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.instr_pc, bus.instr, e.pc, e.ins);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int pc);
        exp_t e;
        e.pc  = PC_W'(pc);
        e.ins = mem[e.pc];
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int spc, input int pend);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.start_pc = PC_W'(spc);
        bus.prog_end = PC_W'(pend);
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Advance until the given PC is presented as valid. The bound is 50 cycles.
    task automatic wait_pc(input int pc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.instr_valid && bus.instr_pc == PC_W'(pc)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Run until done pulses. Also count whether done lasts into the next cycle.
    task automatic run_to_done(output int done_cnt);
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                @(negedge clk);
                if (bus.done) done_cnt++;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%b busy=%b done=%b, expected 0 0 0",
                     bus.instr_valid, bus.busy, bus.done);
        end
        n_cmp++;
        if (bus.imem_addr !== '0 || bus.instr_pc !== '0) begin
            n_err++;
            $display("FAIL reset_pc: got addr=%0d instr_pc=%0d, expected 0 0",
                     bus.imem_addr, bus.instr_pc);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: got busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_linear;
        int v, last_v, done_i;
        bit seen;
        for (int p = 0; p <= 3; p++) push_exp(p);
        do_start(0, 3);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 10'd0) begin
            n_err++;
            $display("FAIL lin_fetch: got busy=%b valid=%b addr=%0d, expected 1 0 0",
                     bus.busy, bus.instr_valid, bus.imem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'd0) begin
            n_err++;
            $display("FAIL lin_latency: got valid=%b pc=%0d, expected 1 0",
                     bus.instr_valid, bus.instr_pc);
        end
        v = 1; last_v = 0; done_i = -1; seen = 1'b0;
        for (int i = 1; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                done_i = i;
            end else if (bus.instr_valid) begin
                v++;
                last_v = i;
            end
        end
        n_cmp++;
        if (!seen || v != 4 || done_i != last_v + 1) begin
            n_err++;
            $display("FAIL lin_done: got seen=%b valids=%0d done_at=%0d, expected 1 4 %0d",
                     seen, v, done_i, last_v + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL lin_after: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL lin_left: got %0d pending, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_branch;
        bit ok;
        int dc;
        push_exp(0); push_exp(1); push_exp(2);
        push_exp(10); push_exp(11); push_exp(12);
        do_start(0, 12);
        wait_pc(2, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL br_reach: got timeout, expected pc 2");
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'd10;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 10'd10) begin
            n_err++;
            $display("FAIL br_bubble: got valid=%b addr=%0d, expected 0 10",
                     bus.instr_valid, bus.imem_addr);
        end
        run_to_done(dc);
        n_cmp++;
        if (dc != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL br_end: got done_cycles=%0d pending=%0d, expected 1 0", dc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_stall;
        bit ok;
        int dc;
        logic [INSTR_W-1:0] s_ins;
        logic [PC_W-1:0] s_addr;
        for (int p = 0; p <= 4; p++) push_exp(p);
        do_start(0, 4);
        wait_pc(1, ok);
        s_ins  = bus.instr;
        s_addr = bus.imem_addr;
        n_cmp++;
        if (!ok || s_addr !== 10'd2) begin
            n_err++;
            $display("FAIL st_reach: got ok=%b addr=%0d, expected 1 2", ok, s_addr);
        end
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) bus.stall = 1'b0;
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'd1 ||
                bus.instr !== s_ins || bus.imem_addr !== s_addr) begin
                n_err++;
                $display("FAIL st_hold%0d: got v=%b pc=%0d ins=%h addr=%0d, expected 1 1 %h %0d",
                         k, bus.instr_valid, bus.instr_pc, bus.instr, bus.imem_addr, s_ins, s_addr);
            end
        end
        run_to_done(dc);
        n_cmp++;
        if (dc != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL st_end: got done_cycles=%0d pending=%0d, expected 1 0", dc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_branch_stall;
        bit ok;
        int dc;
        push_exp(0); push_exp(1);
        for (int p = 5; p <= 8; p++) push_exp(p);
        do_start(0, 8);
        wait_pc(1, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL bs_reach: got timeout, expected pc 1");
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'd5;
        bus.stall         = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 1) bus.stall = 1'b0;
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'd1) begin
                n_err++;
                $display("FAIL bs_stalled%0d: got valid=%b pc=%0d, expected 1 1",
                         k, bus.instr_valid, bus.instr_pc);
            end
        end
        @(negedge clk);
        bus.branch_taken = 1'b0;
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 10'd5) begin
            n_err++;
            $display("FAIL bs_redirect: got valid=%b addr=%0d, expected 0 5",
                     bus.instr_valid, bus.imem_addr);
        end
        run_to_done(dc);
        n_cmp++;
        if (dc != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bs_end: got done_cycles=%0d pending=%0d, expected 1 0", dc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_loop_at_end;
        bit ok;
        int dc;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p <= 5; p++) push_exp(p);
        do_start(0, 5);
        wait_pc(5, ok);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'd0;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        n_cmp++;
        if (!ok || bus.done !== 1'b0 || bus.instr_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL loop_redirect: got ok=%b done=%b valid=%b busy=%b, expected 1 0 0 1",
                     ok, bus.done, bus.instr_valid, bus.busy);
        end
        run_to_done(dc);
        n_cmp++;
        if (dc != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL loop_end: got done_cycles=%0d pending=%0d, expected 1 0", dc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_wrap;
        int dc;
        push_exp(1022); push_exp(1023); push_exp(0); push_exp(1);
        do_start(1022, 1);
        run_to_done(dc);
        n_cmp++;
        if (dc != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_end: got done_cycles=%0d pending=%0d, expected 1 0", dc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset;
        bit ok;
        for (int p = 0; p <= 4; p++) push_exp(p);
        do_start(0, 9);
        wait_pc(4, ok);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (!ok || bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.imem_addr !== '0 || bus.instr_pc !== '0) begin
            n_err++;
            $display("FAIL areset: got ok=%b v=%b busy=%b done=%b addr=%0d pc=%0d, expected 1 0 0 0 0 0",
                     ok, bus.instr_valid, bus.busy, bus.done, bus.imem_addr, bus.instr_pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL areset_left: got %0d pending, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_restart;
        bit ok;
        int dc;
        for (int p = 20; p <= 23; p++) push_exp(p);
        do_start(20, 23);
        wait_pc(21, ok);
        bus.start    = 1'b1;
        bus.start_pc = 10'd40;
        bus.prog_end = 10'd41;
        @(negedge clk);
        bus.start = 1'b0;
        run_to_done(dc);
        n_cmp++;
        if (!ok || dc != 1 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL restart: got ok=%b done_cycles=%0d pending=%0d busy=%b, expected 1 1 0 0",
                     ok, dc, exp_q.size(), bus.busy);
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = INSTR_W'((i * 37 + 11) % 512);
        bus.start         = 1'b0;
        bus.start_pc      = '0;
        bus.prog_end      = '0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;

        test_reset();
        test_linear();
        test_branch();
        test_stall();
        test_branch_stall();
        test_loop_at_end();
        test_wrap();
        test_async_reset();
        test_restart();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
